// File: rtl/spi_slave.sv
// SPI mode-0 slave (MSB first) with a one-word transmit buffer, oversampled on clk.
// Latency: rx_valid pulses 3 clk after the first clk edge that samples sclk high for the last bit.
// Backpressure: none towards the master; a frame starting on an empty buffer sends zeros and pulses underrun.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   sclk, cs_n,     SPI pins from the master, asynchronous to clk
//   mosi, miso
//   tx_data/tx_load write port of the one-word transmit buffer, tx_ready = buffer empty
//   rx_data/rx_valid last complete received word and its one-clk strobe
//   busy            high while a frame is selected (state ACTIVE)
//   underrun        one-clk pulse when a word starts with the transmit buffer empty

module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchronisers: two flops per pin, plus a third on sclk/cs_n for edge detection.
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1,   r_cs_s2,   r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;

  // Counts clk edges after reset release until the synchronisers hold real pin values.
  logic [1:0] r_warm_cnt;

  // Transmit side
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_full;
  logic [WIDTH-1:0] r_tx_shift;
  logic             r_miso;
  logic             r_underrun;

  // Receive side
  logic [WIDTH-1:0] r_rx_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;

  // Event decode
  logic w_warm;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_start;
  logic w_stop;
  logic w_bit_rise;
  logic w_bit_fall;
  logic w_reload;
  logic w_consume;
  logic w_last_bit;
  logic w_load_acc;

  //--------------------------------------------------------------------------
  // Input synchronisers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_warm_cnt <= 2'd0;
    end else if (r_warm_cnt != 2'd3) begin
      r_warm_cnt <= r_warm_cnt + 2'd1;
    end
  end

  // The cs_n flops reset high, so if the master already holds cs_n low when
  // reset is released, the flush of reset values looks like a falling edge.
  // Falling edges are only trusted once all three cs_n flops carry pin data,
  // which makes the block wait for the next genuine frame.
  assign w_warm      = (r_warm_cnt == 2'd3);

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_s3 & w_warm;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;

  assign w_start     = (r_state == IDLE) & w_cs_fall;
  assign w_stop      = (r_state == ACTIVE) & w_cs_rise;

  // Deselect wins over a coincident sclk edge: the frame is over.
  assign w_bit_rise  = (r_state == ACTIVE) & ~w_cs_rise & w_sclk_rise;
  assign w_bit_fall  = (r_state == ACTIVE) & ~w_cs_rise & w_sclk_fall;

  // In mode 0 the first sclk edge of a word is rising, so a falling edge seen
  // with the counter at 0 is the one that follows a completed word: it starts
  // the next word of a continuous frame instead of shifting.
  assign w_reload    = w_bit_fall & (r_bit_cnt == '0);
  assign w_consume   = w_start | w_reload;
  assign w_last_bit  = w_bit_rise & (r_bit_cnt == LAST_BIT);

  // A load is taken when the buffer is empty, or when it is being emptied in
  // this very cycle (the consumer gets the old word, the load refills).
  assign w_load_acc  = tx_load & (~r_tx_full | w_consume);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy     = (r_state == ACTIVE);
    tx_ready = ~r_tx_full;
    miso     = r_miso;
    rx_data  = r_rx_data;
    rx_valid = r_rx_valid;
    underrun = r_underrun;
  end

  //--------------------------------------------------------------------------
  // Transmit buffer
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else if (w_load_acc) begin
      r_tx_buf  <= tx_data;
      r_tx_full <= 1'b1;
    end else if (w_consume) begin
      r_tx_full <= 1'b0;
    end
  end

  //--------------------------------------------------------------------------
  // Transmit shifter and miso
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_stop) begin
        r_miso <= 1'b0;
      end else if (w_consume) begin
        // New word: take the buffered word, or zeros if nothing was loaded.
        r_tx_shift <= r_tx_full ? r_tx_buf : '0;
        r_miso     <= r_tx_full & r_tx_buf[WIDTH-1];
        r_underrun <= ~r_tx_full;
      end else if (w_bit_fall) begin
        // Present the next bit; r_tx_shift[WIDTH-1] is already on the wire.
        r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
        r_miso     <= r_tx_shift[WIDTH-2];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Receive shifter, bit counter and word output
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_done     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;

      // A partial word left by a deselect is simply overwritten by the next
      // word's shifts; only the counter needs clearing.
      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
      end else if (w_bit_rise) begin
        r_rx_shift <= {r_rx_shift[WIDTH-2:0], r_mosi_s2};
        r_bit_cnt  <= w_last_bit ? '0 : r_bit_cnt + CW'(1);
        r_done     <= w_last_bit;
      end

      // Word publish is one cycle after the final shift; the shift register
      // cannot change again before the next sclk rise, many clk later.
      if (r_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 6;   // sclk half period in clk cycles (sclk = clk/12)

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         sclk    = 1'b0;
  logic         cs_n    = 1'b1;
  logic         mosi    = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_load = 1'b0;
  logic         miso;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         underrun;

  int total   = 0;
  int bad     = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int rxv0;
  int und0;
  logic [7:0] got;
  logic [7:0] got2;

  spi_slave #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rx_valid) rxv_cnt++;
    if (underrun) und_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Master side of nbits of a mode-0 word, MSB first. miso is captured just
  // before each sclk rise. keep_high leaves sclk high after the last bit so
  // the caller can drop sclk and raise cs_n together.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit keep_high,
                          input bit lat, output logic [7:0] mi);
    mi = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      mosi = mo[i];
      repeat (HALF) @(negedge clk);
      mi[i] = miso;
      sclk = 1'b1;
      if (lat && k == nbits - 1) begin
        @(posedge clk);                 // first edge that samples sclk high
        @(posedge clk);
        @(posedge clk);
        #1 chk("lat_edge2", rx_valid, 1'b0);
        @(posedge clk);
        #1 chk("lat_edge3", rx_valid, 1'b1);
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (!(keep_high && k == nbits - 1)) sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    chk("rst_miso",     miso,     1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_data",  rx_data,  8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // ---------------- single frame: tx A5, rx 3C ----------------
    load(8'hA5);
    chk("f1_tx_ready_low", tx_ready, 1'b0);
    rxv0 = rxv_cnt; und0 = und_cnt;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("f1_busy", busy, 1'b1);
    spi_xfer(8'h3C, 8, 1'b1, 1'b1, got);
    end_frame();
    chk("f1_miso_word", got, 8'hA5);
    chk("f1_rx_data", rx_data, 8'h3C);
    chk("f1_rx_valid_cnt", rxv_cnt, rxv0 + 1);
    chk("f1_underrun_cnt", und_cnt, und0);
    chk("f1_tx_ready_back", tx_ready, 1'b1);
    chk("f1_busy_after", busy, 1'b0);
    chk("f1_miso_idle", miso, 1'b0);

    // ---------------- empty buffer: underrun, zeros out ----------------
    rxv0 = rxv_cnt; und0 = und_cnt;
    cs_n = 1'b0;
    spi_xfer(8'h55, 8, 1'b1, 1'b0, got);
    end_frame();
    chk("ur_miso_word", got, 8'h00);
    chk("ur_underrun_cnt", und_cnt, und0 + 1);
    chk("ur_rx_data", rx_data, 8'h55);
    chk("ur_rx_valid_cnt", rxv_cnt, rxv0 + 1);

    // ---------------- back-to-back words, reload during word 1 ----------------
    load(8'h3C);
    rxv0 = rxv_cnt; und0 = und_cnt;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    load(8'h81);
    chk("b2b_tx_ready_low", tx_ready, 1'b0);
    spi_xfer(8'h12, 8, 1'b0, 1'b0, got);
    spi_xfer(8'h34, 8, 1'b1, 1'b0, got2);
    end_frame();
    chk("b2b_word1", got, 8'h3C);
    chk("b2b_word2", got2, 8'h81);
    chk("b2b_rx_valid_cnt", rxv_cnt, rxv0 + 2);
    chk("b2b_underrun_cnt", und_cnt, und0);
    chk("b2b_rx_data", rx_data, 8'h34);
    chk("b2b_tx_ready", tx_ready, 1'b1);

    // ---------------- second load while full is ignored ----------------
    load(8'h11);
    load(8'h22);
    chk("dbl_tx_ready_low", tx_ready, 1'b0);
    cs_n = 1'b0;
    spi_xfer(8'h00, 8, 1'b1, 1'b0, got);
    end_frame();
    chk("dbl_miso_word", got, 8'h11);
    chk("dbl_tx_ready", tx_ready, 1'b1);
    chk("dbl_rx_data", rx_data, 8'h00);

    // ---------------- load in the same cycle as consumption ----------------
    load(8'h66);
    und0 = und_cnt;
    cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_data = 8'h77;
    tx_load = 1'b1;                     // coincides with the cs_n-fall consumption
    @(negedge clk);
    tx_load = 1'b0;
    chk("sim_tx_ready_low", tx_ready, 1'b0);
    spi_xfer(8'hF0, 8, 1'b1, 1'b0, got);
    end_frame();
    chk("sim_old_word", got, 8'h66);
    cs_n = 1'b0;
    spi_xfer(8'h0F, 8, 1'b1, 1'b0, got);
    end_frame();
    chk("sim_new_word", got, 8'h77);
    chk("sim_tx_ready", tx_ready, 1'b1);
    chk("sim_rx_data", rx_data, 8'h0F);
    chk("sim_underrun_cnt", und_cnt, und0);

    // ---------------- abort after 5 bits ----------------
    load(8'hC7);
    rxv0 = rxv_cnt;
    cs_n = 1'b0;
    spi_xfer(8'hFF, 5, 1'b0, 1'b0, got);
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_rx_valid_cnt", rxv_cnt, rxv0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rx_data", rx_data, 8'h0F);
    chk("abort_miso", miso, 1'b0);
    load(8'h96);
    rxv0 = rxv_cnt;
    cs_n = 1'b0;
    spi_xfer(8'hC3, 8, 1'b1, 1'b0, got);
    end_frame();
    chk("abort_next_miso", got, 8'h96);
    chk("abort_next_rx_data", rx_data, 8'hC3);
    chk("abort_next_rx_valid_cnt", rxv_cnt, rxv0 + 1);

    // ---------------- reset mid-word, released with cs_n low ----------------
    load(8'hFF);
    cs_n = 1'b0;
    spi_xfer(8'h0F, 4, 1'b0, 1'b0, got);
    repeat (4) @(negedge clk);
    chk("mid_miso_pre", miso, 1'b1);
    chk("mid_busy_pre", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_miso",     miso,     1'b0);
    chk("mid_rst_busy",     busy,     1'b0);
    chk("mid_rst_tx_ready", tx_ready, 1'b1);
    chk("mid_rst_rx_data",  rx_data,  8'h00);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    chk("mid_rst_underrun", underrun, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rxv0 = rxv_cnt; und0 = und_cnt;
    spi_xfer(8'hFF, 4, 1'b0, 1'b0, got);
    repeat (4) @(negedge clk);
    chk("rel_busy", busy, 1'b0);
    chk("rel_miso", miso, 1'b0);
    chk("rel_rx_valid_cnt", rxv_cnt, rxv0);
    chk("rel_underrun_cnt", und_cnt, und0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rel_tx_ready", tx_ready, 1'b1);
    load(8'h5A);
    rxv0 = rxv_cnt;
    cs_n = 1'b0;
    spi_xfer(8'hA5, 8, 1'b1, 1'b0, got);
    end_frame();
    chk("rel_next_miso", got, 8'h5A);
    chk("rel_next_rx_data", rx_data, 8'hA5);
    chk("rel_next_rx_valid_cnt", rxv_cnt, rxv0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: WIDTH, default 8, frame length in bits; legal values 2..32.
REQ-002 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 sclk  input  1  SPI serial clock from the master; asynchronous to clk.
REQ-005 cs_n  input  1  SPI chip select from the master, active-low; asynchronous to clk.
REQ-006 mosi  input  1  serial data from the master; asynchronous to clk.
REQ-007 miso  output  1  serial data to the master; registered.
REQ-008 tx_data  input  WIDTH  word for the next frame.
REQ-009 tx_load  input  1  strobe that writes tx_data into the transmit buffer.
REQ-010 tx_ready  output  1  high while the transmit buffer is empty.
REQ-011 rx_data  output  WIDTH  last complete received word.
REQ-012 rx_valid  output  1  one-clk pulse marking a new rx_data value.
REQ-013 busy  output  1  high while the block is in state ACTIVE.
REQ-014 underrun  output  1  one-clk pulse when a word starts with an empty transmit buffer.

Function
REQ-015 Protocol: SPI mode 0 (CPOL=0, CPHA=0), MSB first; the block samples mosi on sclk rising edges and updates miso on sclk falling edges.
REQ-016 Synchronisation: sclk, cs_n and mosi each pass through two flops; sclk and cs_n edges are detected with a third flop.
REQ-017 Timing: the guaranteed operating range is sclk frequency <= clk/8.
REQ-018 State machine: two states, IDLE and ACTIVE.
REQ-019 IDLE -> ACTIVE: on a synchronised cs_n falling edge, with these actions:
  - bit counter set to 0;
  - shift register loaded from the transmit buffer, or all-zero if the buffer is empty (underrun pulses);
  - buffer marked empty;
  - miso driven with the shift register MSB.
REQ-020 Each synchronised sclk rising edge in ACTIVE:
  - shifts mosi into the receive register LSB;
  - increments the bit counter.
REQ-021 Synchronised sclk falling edge in ACTIVE:
  - drives miso with the next transmit bit;
  - does not shift on the falling edge that follows bit WIDTH-1.
REQ-022 Completion: on the rising edge that completes bit WIDTH-1:
  - rx_data takes the assembled word;
  - rx_valid pulses for exactly one clk;
  - the bit counter wraps to 0.
REQ-023 Continuous framing: if cs_n stays low after a word completes, the next sclk falling edge reloads the shift register per REQ-019 and drives its MSB on miso.
REQ-024 ACTIVE -> IDLE: on a synchronised cs_n rising edge at any bit count, with these actions:
  - a partial word is discarded, with no rx_valid;
  - the bit counter is cleared;
  - miso is driven 0.
REQ-025 Latency: rx_valid asserts 3 clk cycles after the first clk edge that samples sclk high for bit WIDTH-1.
REQ-026 Transmit buffer:
  - tx_load while tx_ready=1 captures tx_data, and tx_ready falls the next cycle;
  - tx_load while tx_ready=0 is ignored, and the buffer contents are unchanged.
REQ-027 Simultaneous tx_load and buffer consumption in the same cycle: consumption takes the old contents; the load then fills the buffer, and tx_ready stays 0.
REQ-028 sclk edges while in IDLE are ignored.
REQ-029 busy equals (state == ACTIVE).

Reset
REQ-030 While rst=0, the block holds the following, independent of clk:
  - state IDLE, counters 0, transmit buffer empty;
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0;
  - all synchroniser flops: sclk flops 0, cs_n flops 1.
REQ-031 Reset released mid-frame with cs_n already low: the block waits in IDLE for the next cs_n falling edge and ignores the current frame.

Verification
REQ-032 Load 0xA5 and run one 8-bit frame with mosi=0x3C: miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready returns to 1.
REQ-033 Two back-to-back words with cs_n held low, buffer reloaded with 0x81 during word 1: second word shifts out 0x81; two rx_valid pulses; no underrun.
REQ-034 Frame started with an empty buffer: underrun pulses once; miso shifts 0x00.
REQ-035 cs_n raised after 5 bits: no rx_valid; busy=0; rx_data unchanged; the next full frame is received correctly.
REQ-036 tx_load of 0x11 then 0x22 with no frame in between: 0x11 is transmitted and 0x22 is ignored.
REQ-037 rst asserted mid-word: all outputs reach their reset values immediately, with no clk edge required.
